bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Shares the 3-bit tri-state datapath bus between up to NUM_REQ requesters (control FSM, data-load port, debug port, ...). Each request names one bus source (tri-state index) and one destination (load-enable index); the block grants one requester per cycle with round-robin fairness and a lock for back-to-back transfers. It drives one-hot source enables and destination load enables for the register file, A/B operand latches and G/H ALU outputs.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- SRC_NUM, 11, tri-state sources (8 registers, data, H, G)
- DST_NUM, 14, load destinations (8 registers, 6 general enables)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester transfer request
- lock  in  NUM_REQ  per-requester hold-bus request
- src_sel  in  4*NUM_REQ  source index, requester i at [4i+3:4i]
- dst_sel  in  4*NUM_REQ  destination index, same packing
- gnt  out  NUM_REQ  one-hot grant, high in the transfer cycle
- err  out  1  pulse: granted request had an out-of-range index
- tri_en  out  SRC_NUM  one-hot bus source enable
- ld_en  out  DST_NUM  one-hot destination load enable
- busy  out  1  high in any transfer or turnaround cycle

## Operation
- States: IDLE, XFER, TURN (TURN exists only with the macro).
- Reset: state IDLE, gnt/tri_en/ld_en/err/busy all 0, round-robin pointer 0, last-owner invalid. Bus floats.
- Eligible set: req bits, minus the current owner unless its lock is 1.
- Arbitration: first eligible index at or after pointer, wrapping modulo NUM_REQ. Pointer becomes winner+1 (wraps to 0 past NUM_REQ-1).
- Locked owner: if owner has req=1 and lock=1, it wins again regardless of pointer, and the pointer does not move.
- Transfer: winner's src_sel, dst_sel decode to one bit each of tri_en and ld_en. gnt[winner]=1 and busy=1 for that cycle.
- Range error: src_sel>=SRC_NUM or dst_sel>=DST_NUM. The requester is still granted (gnt=1) and err=1. tri_en and ld_en stay 0 and the pointer advances normally.
- No eligible request: go to or stay in IDLE, all enables 0, busy 0.
- Requester rule: hold req/src_sel/dst_sel stable until gnt is seen. After one gnt the request is consumed. A requester re-arbitrates the cycle after next unless it holds lock.
- Dropping lock releases the bus: the owner loses eligibility for the next cycle.
- tri_en and ld_en are never multi-hot. tri_en is never nonzero in two adjacent cycles with different owners when the macro is on.

## Timing
- All outputs registered. Inputs sampled at edge n; gnt/tri_en/ld_en valid throughout cycle n+1. Request-to-grant latency is 1 cycle.
- Destination loads on the edge ending cycle n+1.
- A locked owner gets one transfer per cycle. Unlocked requesters alternate, with at most one grant per requester per 2 cycles.
- Asynchronous reset mid-transfer clears all outputs immediately. Any in-flight transfer is lost and no gnt is reported.

## Configuration
- BUS_TURNAROUND_EN defined: when the next winner differs from the previous cycle's owner, the block inserts one TURN cycle. In TURN, busy=1, gnt/tri_en/ld_en=0, and the winner is granted in the following cycle. Arbitration is frozen during TURN. An idle gap of 1 or more cycles satisfies turnaround, so no TURN is needed after it.
- Undefined: no TURN state, and different owners may transfer in adjacent cycles.

## Test plan
- Single request: req=0001, src_sel0=8, dst_sel0=3 at edge 0 -> cycle 1: gnt=0001, tri_en=bit8, ld_en=bit3, busy=1. Cycle 2: all 0.
- Round robin: req=1111 held, lock=0, macro off -> grant order 0,1,2,3,0. No requester is granted in adjacent cycles.
- Lock: req0=lock0=1 for 4 cycles while req1=1 -> gnt0 for 4 consecutive cycles. Drop lock0 -> gnt1 next cycle, pointer=2.
- Range error: src_sel=12 with SRC_NUM=11 -> gnt=1, err=1, tri_en=0, ld_en=0. The next requester is served the following cycle.
- Turnaround (macro on): req=0011 -> gnt0, TURN cycle (busy=1, enables 0), then gnt1. Repeat with the macro off -> gnt0, gnt1 back-to-back.
- Reset mid-transfer: assert rst=0 during a gnt cycle -> all outputs 0 immediately. After release, the pointer restarts at 0 and requester 0 wins first.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 3-bit tri-state datapath bus, with owner lock.
// Optional BUS_TURNAROUND_EN inserts one dead TURN cycle between different owners.
module bus_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned SRC_NUM = 11,
    parameter int unsigned DST_NUM = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     lock,
    input  logic [4*NUM_REQ-1:0]   src_sel,
    input  logic [4*NUM_REQ-1:0]   dst_sel,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   err,
    output logic [SRC_NUM-1:0]     tri_en,
    output logic [DST_NUM-1:0]     ld_en,
    output logic                   busy
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        XFER
`ifdef BUS_TURNAROUND_EN
        , TURN
`endif
    } state_t;

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       owner;
`ifdef BUS_TURNAROUND_EN
    logic [IW-1:0]       pend;
`endif

    logic [NUM_REQ-1:0]  eligible;
    logic                locked_win;
    logic                found;
    logic [IW-1:0]       win;
    logic [IW-1:0]       cand;
    logic [IW-1:0]       ptr_nxt;
    logic [IW-1:0]       g_idx;
    logic [3:0]          g_src;
    logic [3:0]          g_dst;
    logic                g_err;
    logic [NUM_REQ-1:0]  g_gnt;
    logic [SRC_NUM-1:0]  g_tri;
    logic [DST_NUM-1:0]  g_ld;

    // Owner is only meaningful while a transfer is on the bus (state XFER).
    always_comb begin
        eligible = req;
        if (state == XFER && !lock[owner])
            eligible[owner] = 1'b0;
        locked_win = (state == XFER) && req[owner] && lock[owner];

        found = 1'b0;
        win   = ptr;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IW'((32'(ptr) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (locked_win) begin
            found = 1'b1;
            win   = owner;
        end
        ptr_nxt = (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

        g_idx = win;
`ifdef BUS_TURNAROUND_EN
        if (state == TURN)
            g_idx = pend;
`endif
        g_src = src_sel[{g_idx, 2'b00} +: 4];
        g_dst = dst_sel[{g_idx, 2'b00} +: 4];
        g_gnt = '0;
        g_gnt[g_idx] = 1'b1;
        g_tri = '0;
        g_ld  = '0;
        g_err = (32'(g_src) >= SRC_NUM) || (32'(g_dst) >= DST_NUM);
        if (!g_err) begin
            g_tri[g_src] = 1'b1;
            g_ld[g_dst]  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
`ifdef BUS_TURNAROUND_EN
            pend   <= '0;
`endif
            gnt    <= '0;
            tri_en <= '0;
            ld_en  <= '0;
            err    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            gnt    <= '0;
            tri_en <= '0;
            ld_en  <= '0;
            err    <= 1'b0;
            busy   <= 1'b0;
            case (state)
`ifdef BUS_TURNAROUND_EN
                TURN: begin
                    // Winner and pointer were settled when TURN was entered.
                    state  <= XFER;
                    owner  <= pend;
                    gnt    <= g_gnt;
                    tri_en <= g_tri;
                    ld_en  <= g_ld;
                    err    <= g_err;
                    busy   <= 1'b1;
                end
`endif
                default: begin
                    if (!found) begin
                        state <= IDLE;
`ifdef BUS_TURNAROUND_EN
                    end else if (state == XFER && win != owner) begin
                        state <= TURN;
                        pend  <= win;
                        ptr   <= ptr_nxt;
                        busy  <= 1'b1;
`endif
                    end else begin
                        state  <= XFER;
                        owner  <= win;
                        gnt    <= g_gnt;
                        tri_en <= g_tri;
                        ld_en  <= g_ld;
                        err    <= g_err;
                        busy   <= 1'b1;
                        if (!locked_win)
                            ptr <= ptr_nxt;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter; expectations are hand-computed.
module tb_bus_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SRC_NUM = 11;
    localparam int unsigned DST_NUM = 14;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    lock;
    logic [4*NUM_REQ-1:0]  src_sel;
    logic [4*NUM_REQ-1:0]  dst_sel;
    logic [NUM_REQ-1:0]    gnt;
    logic                  err;
    logic [SRC_NUM-1:0]    tri_en;
    logic [DST_NUM-1:0]    ld_en;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(
        .NUM_REQ(NUM_REQ),
        .SRC_NUM(SRC_NUM),
        .DST_NUM(DST_NUM)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .lock   (lock),
        .src_sel(src_sel),
        .dst_sel(dst_sel),
        .gnt    (gnt),
        .err    (err),
        .tri_en (tri_en),
        .ld_en  (ld_en),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] g, input logic [31:0] t,
                              input logic [31:0] l, input logic e, input logic b);
        check({tag, ".gnt"},    32'(gnt),    g);
        check({tag, ".tri_en"}, 32'(tri_en), t);
        check({tag, ".ld_en"},  32'(ld_en),  l);
        check({tag, ".err"},    32'(err),    32'(e));
        check({tag, ".busy"},   32'(busy),   32'(b));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int i, input logic [3:0] s, input logic [3:0] d);
        src_sel[4*i +: 4] = s;
        dst_sel[4*i +: 4] = d;
    endtask

    // Called 1 time unit after a rising edge; reset pulse ends well before the next one.
    task automatic pulse_reset;
        req  = '0;
        lock = '0;
        rst  = 1'b0;
        #3;
        rst  = 1'b1;
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        lock    = '0;
        src_sel = '0;
        dst_sel = '0;
        #1 rst = 1'b0;
        #2;
        expect_out("reset", 0, 0, 0, 1'b0, 1'b0);
        #9 rst = 1'b1;
        tick;

        // Single request, then nothing.
        set_sel(0, 4'd8, 4'd3);
        req = 4'b0001;
        tick;
        expect_out("single", 32'h1, 32'h100, 32'h8, 1'b0, 1'b1);
        req = 4'b0000;
        tick;
        expect_out("single_idle", 0, 0, 0, 1'b0, 1'b0);

        // Round robin with all requesting, no lock.
        pulse_reset;
        for (int i = 0; i < 4; i++) set_sel(i, 4'(i), 4'(i + 4));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick;
`ifdef BUS_TURNAROUND_EN
            if (k != 0) begin
                expect_out($sformatf("rr_turn%0d", k), 0, 0, 0, 1'b0, 1'b1);
                tick;
            end
`endif
            check($sformatf("rr%0d.gnt", k),    32'(gnt),    32'(1) << (k % 4));
            check($sformatf("rr%0d.tri_en", k), 32'(tri_en), 32'(1) << (k % 4));
            check($sformatf("rr%0d.ld_en", k),  32'(ld_en),  32'(1) << (k % 4 + 4));
        end
        req = '0;
        tick;
        expect_out("rr_idle", 0, 0, 0, 1'b0, 1'b0);

        // Lock: requester 0 keeps the bus while requester 1 waits.
        pulse_reset;
        set_sel(0, 4'd2, 4'd9);
        set_sel(1, 4'd10, 4'd13);
        req  = 4'b0011;
        lock = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick;
            expect_out($sformatf("lock%0d", k), 32'h1, 32'h4, 32'h200, 1'b0, 1'b1);
        end
        lock = 4'b0000;
        tick;
`ifdef BUS_TURNAROUND_EN
        expect_out("unlock_turn", 0, 0, 0, 1'b0, 1'b1);
        tick;
`endif
        expect_out("unlock", 32'h2, 32'h400, 32'h2000, 1'b0, 1'b1);
        req = 4'b0000;
        tick;
        expect_out("unlock_idle", 0, 0, 0, 1'b0, 1'b0);
        // Pointer is now 2: requester 2 beats 0 and 1.
        set_sel(2, 4'd7, 4'd0);
        req = 4'b0111;
        tick;
        expect_out("ptr_after_lock", 32'h4, 32'h80, 32'h1, 1'b0, 1'b1);

        // Range errors on source and destination.
        pulse_reset;
        set_sel(0, 4'd12, 4'd1);
        set_sel(1, 4'd5, 4'd6);
        req = 4'b0011;
        tick;
        expect_out("src_range", 32'h1, 0, 0, 1'b1, 1'b1);
        req = 4'b0010;
        tick;
`ifdef BUS_TURNAROUND_EN
        expect_out("range_turn", 0, 0, 0, 1'b0, 1'b1);
        tick;
`endif
        expect_out("after_range", 32'h2, 32'h20, 32'h40, 1'b0, 1'b1);
        pulse_reset;
        set_sel(2, 4'd0, 4'd14);
        req = 4'b0100;
        tick;
        expect_out("dst_range", 32'h4, 0, 0, 1'b1, 1'b1);

        // Two owners in succession: TURN only when the macro is on.
        pulse_reset;
        set_sel(0, 4'd9, 4'd0);
        set_sel(1, 4'd3, 4'd7);
        req = 4'b0011;
        tick;
        expect_out("ta_first", 32'h1, 32'h200, 32'h1, 1'b0, 1'b1);
        req = 4'b0010;
        tick;
`ifdef BUS_TURNAROUND_EN
        expect_out("ta_turn", 0, 0, 0, 1'b0, 1'b1);
        tick;
`endif
        expect_out("ta_second", 32'h2, 32'h8, 32'h80, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a grant cycle.
        pulse_reset;
        set_sel(0, 4'd1, 4'd2);
        req = 4'b0001;
        tick;
        expect_out("pre_rst", 32'h1, 32'h2, 32'h4, 1'b0, 1'b1);
        #2 rst = 1'b0;
        #1;
        expect_out("mid_rst", 0, 0, 0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        req = 4'b0011;
        tick;
        expect_out("post_rst", 32'h1, 32'h2, 32'h4, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
